// File: rtl/fifo_pkg.sv
// Shared definitions for the team fifo and its read-side engines.
package fifo_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_BURST = 2'd1;
  localparam logic [ST_W-1:0] ST_FLUSH = 2'd2;

  // Occupancy width for a fifo of the given DEPTH (usable capacity DEPTH-1).
  function automatic int unsigned level_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_drain_skid2.sv
// Two-entry valid/ready output buffer; head word is presented, tail absorbs one extra pop.
module skid2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             room_c,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  input  logic             ready
);

  logic [1:0]       occ;
  logic [1:0]       occ_nxt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] tail_nxt;
  logic             pop_c;

  assign pop_c  = (occ != 2'd0) && ready;
  assign room_c = (occ != 2'd2);
  assign data   = head;

  // Head is cleared whenever the buffer empties so data reads 0 with no word held.
  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    tail_nxt = tail;
    case ({push, pop_c})
      2'b10: begin
        if (occ == 2'd0) begin
          head_nxt = push_data;
          occ_nxt  = 2'd1;
        end else begin
          tail_nxt = push_data;
          occ_nxt  = 2'd2;
        end
      end
      2'b01: begin
        if (occ == 2'd2) begin
          head_nxt = tail;
          occ_nxt  = 2'd1;
        end else begin
          head_nxt = '0;
          occ_nxt  = 2'd0;
        end
      end
      2'b11: begin
        if (occ == 2'd2) begin
          head_nxt = tail;
          tail_nxt = push_data;
        end else begin
          head_nxt = push_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      occ   <= 2'd0;
      head  <= '0;
      tail  <= '0;
      valid <= 1'b0;
    end else begin
      occ   <= occ_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
      valid <= (occ_nxt != 2'd0);
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// Read-side engine for an FWFT fifo: pops in bursts of BURST or drains fully on flush,
// forwarding words through a 2-entry buffer onto a valid/ready stream.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BURST = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [WIDTH-1:0]                     i_fifo_data,
  input  logic [fifo_pkg::level_width(DEPTH)-1:0] i_fifo_level,
  input  logic                                 i_fifo_empty,
  output logic                                 o_fifo_read,
  input  logic                                 i_flush,
  output logic                                 o_valid,
  output logic [WIDTH-1:0]                     o_data,
  input  logic                                 i_ready,
  output logic                                 o_busy,
  output logic                                 o_flush_done
);

  localparam int unsigned LW = level_width(DEPTH);
  localparam int unsigned CW = $clog2(BURST + 1);

  localparam logic [LW-1:0] BURST_LVL  = LW'(BURST);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   beat_cnt_nxt;
  logic            flush_pend;
  logic            flush_pend_nxt;
  logic            flush_clr;
  logic            flush_done_nxt;
  logic            busy_nxt;
  logic            room_c;
  logic            read_c;

  // Pop strobe decoded from registered state, gated by fifo and buffer availability.
  assign read_c      = (state != ST_IDLE) && !i_fifo_empty && room_c;
  assign o_fifo_read = read_c;

  always_comb begin
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    flush_clr      = 1'b0;
    flush_done_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush_pend) begin
          if (!i_fifo_empty) begin
            state_nxt = ST_FLUSH;
          end else begin
            flush_clr      = 1'b1;
            flush_done_nxt = 1'b1;
          end
        end else if (i_fifo_level >= BURST_LVL) begin
          state_nxt    = ST_BURST;
          beat_cnt_nxt = '0;
        end
      end
      ST_BURST: begin
        if (read_c) begin
          if (beat_cnt == BURST_LAST) begin
            state_nxt    = ST_IDLE;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + CW'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (i_fifo_empty) begin
          state_nxt      = ST_IDLE;
          flush_clr      = 1'b1;
          flush_done_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // A new flush request wins over the clear from a completing one.
    flush_pend_nxt = i_flush | (flush_pend & ~flush_clr);
    busy_nxt       = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      flush_pend   <= 1'b0;
      o_busy       <= 1'b0;
      o_flush_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      beat_cnt     <= beat_cnt_nxt;
      flush_pend   <= flush_pend_nxt;
      o_busy       <= busy_nxt;
      o_flush_done <= flush_done_nxt;
    end
  end

  skid2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .push     (read_c),
    .push_data(i_fifo_data),
    .room_c   (room_c),
    .valid    (o_valid),
    .data     (o_data),
    .ready    (i_ready)
  );

endmodule
